// File: rtl/vga_sync_gen_pkg.sv
// 640x480@60 timing constants shared by the sync generator and the paint stage,
// plus the small helpers used to decode sync/visible windows.
package vga_sync_gen_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  // Registered decode outputs; syncs are active low.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } dec_t;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_win(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_mod_counter.sv
// Modulo-MOD enabled counter; also exposes its next-state value so the caller can
// register decodes that line up with the post-edge count.
module mod_counter #(
  parameter int MOD = 800,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;
  logic         at_max;

  assign at_max = (count_q == W'(MOD - 1));

  always_comb begin
    count_d = count_q;
    if (en) count_d = at_max ? '0 : count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count     = count_q;
  assign count_nxt = count_d;
  assign wrap      = en & at_max;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: 25 MHz pixel tick from the 50 MHz clock, x/y counters and
// registered sync/visible decode that is always coherent with cur_x/cur_y.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cur_x,
  output logic [CNT_W-1:0] cur_y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             pix_tick,
  output logic             frame_end
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic             pix_tick_q;
  logic [CNT_W-1:0] x_q, x_nxt, y_q, y_nxt;
  logic             h_wrap, v_wrap;
  dec_t             dec_q, dec_d;

  always_ff @(posedge clk) begin
    if (rst) pix_tick_q <= 1'b0;
    else     pix_tick_q <= ~pix_tick_q;
  end

  mod_counter #(.MOD(H_TOTAL), .W(CNT_W)) u_hcnt (
    .clk      (clk),
    .rst      (rst),
    .en       (pix_tick_q),
    .count    (x_q),
    .count_nxt(x_nxt),
    .wrap     (h_wrap)
  );

  mod_counter #(.MOD(V_TOTAL), .W(CNT_W)) u_vcnt (
    .clk      (clk),
    .rst      (rst),
    .en       (h_wrap),
    .count    (y_q),
    .count_nxt(y_nxt),
    .wrap     (v_wrap)
  );

  // Decode from the next-state counts so the registered flags match cur_x/cur_y.
  always_comb begin
    dec_d          = '0;
    dec_d.hsync    = ~in_win(x_nxt, HS_START, HS_END);
    dec_d.vsync    = ~in_win(y_nxt, VS_START, VS_END);
    dec_d.video_on = in_win(x_nxt, 0, H_ACTIVE) & in_win(y_nxt, 0, V_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) dec_q <= '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};
    else     dec_q <= dec_d;
  end

  assign cur_x     = x_q;
  assign cur_y     = y_q;
  assign hsync     = dec_q.hsync;
  assign vsync     = dec_q.vsync;
  assign video_on  = dec_q.video_on;
  assign pix_tick  = pix_tick_q;
  // v_wrap is pix_tick & last x & last y: the final pixel of the frame.
  assign frame_end = v_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: a full-size instance for line timing and a shrunk-porch instance for
// frame/vsync timing, each scored cycle by cycle against a reference model.
module tb_vga_sync_gen;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp;
  } tp_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
  } st_t;

  tp_t big_p = '{640, 16, 96, 48, 480, 10, 2, 33};
  tp_t sml_p = '{16, 2, 4, 3, 8, 2, 2, 3};

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_hs, a_vs, a_vo, a_pt, a_fe;
  logic       b_hs, b_vs, b_vo, b_pt, b_fe;

  vga_sync_gen u_big (
    .clk(clk), .rst(rst_a), .cur_x(a_x), .cur_y(a_y), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_vo), .pix_tick(a_pt), .frame_end(a_fe)
  );

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_sml (
    .clk(clk), .rst(rst_b), .cur_x(b_x), .cur_y(b_y), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vo), .pix_tick(b_pt), .frame_end(b_fe)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one clk edge of the spec'd behaviour.
  function automatic st_t nxt(input st_t s, input logic r, input tp_t p);
    st_t n;
    int  ht, vt, hss, vss;
    ht  = p.ha + p.hfp + p.hs + p.hbp;
    vt  = p.va + p.vfp + p.vs + p.vbp;
    hss = p.ha + p.hfp;
    vss = p.va + p.vfp;
    if (r) return '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b0, pt: 1'b0};
    n    = s;
    n.pt = ~s.pt;
    if (s.pt) begin
      if (int'(s.x) == ht - 1) begin
        n.x = 10'd0;
        n.y = (int'(s.y) == vt - 1) ? 10'd0 : 10'(int'(s.y) + 1);
      end else begin
        n.x = 10'(int'(s.x) + 1);
      end
    end
    n.hs = !(int'(n.x) >= hss && int'(n.x) < hss + p.hs);
    n.vs = !(int'(n.y) >= vss && int'(n.y) < vss + p.vs);
    n.vo = (int'(n.x) < p.ha) && (int'(n.y) < p.va);
    return n;
  endfunction

  function automatic logic [24:0] pack_exp(input st_t s, input tp_t p);
    logic fe;
    fe = s.pt && int'(s.x) == p.ha + p.hfp + p.hs + p.hbp - 1
              && int'(s.y) == p.va + p.vfp + p.vs + p.vbp - 1;
    return {s.x, s.y, s.hs, s.vs, s.vo, s.pt, fe};
  endfunction

  st_t         ma = '0, mb = '0;
  logic [24:0] qa[$], qb[$];

  always @(posedge clk) begin : mdl_a
    st_t n;
    n = nxt(ma, rst_a, big_p);
    ma <= n;
    qa.push_back(pack_exp(n, big_p));
  end

  always @(posedge clk) begin : mdl_b
    st_t n;
    n = nxt(mb, rst_b, sml_p);
    mb <= n;
    qb.push_back(pack_exp(n, sml_p));
  end

  always @(negedge clk) begin
    if (qa.size() > 0) chk("big_outs", 32'({a_x, a_y, a_hs, a_vs, a_vo, a_pt, a_fe}), 32'(qa.pop_front()));
    if (qb.size() > 0) chk("sml_outs", 32'({b_x, b_y, b_hs, b_vs, b_vo, b_pt, b_fe}), 32'(qb.pop_front()));
  end

  // Full-size: reset, first line, mid-line reset and restart.
  task automatic run_big();
    int hs_lo, k;
    logic [9:0] px, py;
    repeat (5) @(negedge clk);
    chk("rst_x", 32'(a_x), 32'd0);
    chk("rst_y", 32'(a_y), 32'd0);
    chk("rst_sync", 32'({a_hs, a_vs}), 32'd3);
    chk("rst_vo", 32'(a_vo), 32'd0);
    chk("rst_pt", 32'(a_pt), 32'd0);
    rst_a = 1'b0;
    @(negedge clk);
    chk("e1_pt_vo", 32'({a_pt, a_vo}), 32'd3);
    chk("e1_xy", 32'({a_x, a_y}), 32'd0);
    hs_lo = (a_hs == 1'b0) ? 1 : 0;
    px = a_x; py = a_y;
    for (int i = 1; i < 1600; i++) begin
      px = a_x; py = a_y;
      @(negedge clk);
      if (a_hs == 1'b0) hs_lo++;
    end
    chk("line_prev_x", 32'(px), 32'd799);
    chk("line_prev_y", 32'(py), 32'd0);
    chk("line_end_xy", 32'({a_x, a_y}), 32'({10'd0, 10'd1}));
    chk("hsync_clks", 32'(hs_lo), 32'd192);
    k = 0;
    while (!(a_x == 10'd300 && a_y == 10'd1) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_300_1", 32'(k < 4000), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_rst_xy", 32'({a_x, a_y}), 32'd0);
    chk("mid_rst_misc", 32'({a_hs, a_vs, a_vo, a_pt}), 32'b1100);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("re_e1", 32'({a_x, a_pt, a_vo, a_hs}), 32'({10'd0, 3'b111}));
    @(negedge clk);
    chk("re_e2", 32'({a_x, a_pt}), 32'({10'd1, 1'b0}));
  endtask

  // Shrunk porches (25 x 15): frame wrap, frame length, vsync width, mid-frame reset.
  task automatic run_sml();
    int k, cnt, vs_lo;
    repeat (5) @(negedge clk);
    rst_b = 1'b0;
    k = 0;
    while (!b_fe && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("fe_seen", 32'(k < 2000), 32'd1);
    chk("fe_pos", 32'({b_x, b_y, b_pt}), 32'({10'd24, 10'd14, 1'b1}));
    cnt = 0; vs_lo = 0;
    @(negedge clk);
    cnt++;
    chk("fe_width", 32'(b_fe), 32'd0);
    chk("wrap_xy", 32'({b_x, b_y}), 32'd0);
    if (!b_vs) vs_lo++;
    while (!b_fe && cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (!b_vs) vs_lo++;
    end
    chk("frame_clks", 32'(cnt), 32'd750);
    chk("vsync_clks", 32'(vs_lo), 32'd100);
    k = 0;
    while (!(b_x == 10'd10 && b_y == 10'd5) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_10_5", 32'(k < 2000), 32'd1);
    rst_b = 1'b1;
    @(negedge clk);
    chk("sml_rst", 32'({b_x, b_y, b_hs, b_vs, b_vo, b_pt}), 32'({20'd0, 4'b1100}));
    rst_b = 1'b0;
    repeat (800) @(negedge clk);
  endtask

  initial begin
    fork
      run_big();
      run_sml();
    join
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
